// File: rtl/stream_mux_n1.sv
// stream_mux_n1: parametrised N:1 valid/ready stream multiplexer.
// Channel chosen by explicit select (mode=0) or round-robin (mode=1);
// the selected word is captured in a single registered output stage.
module stream_mux_n1 #(
    parameter int N_CH   = 8,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_valid,
    output logic [N_CH-1:0]          in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam logic [SEL_W:0]   NCH_W = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(N_CH - 1);

    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_ch_q, out_ch_d;
    logic              out_valid_q, out_valid_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic              load;
    logic              xfer;
    logic [SEL_W-1:0]  grant;
    logic              grant_ok;
    logic [SEL_W:0]    idx;
    logic [DATA_W-1:0] grant_data;

    assign load = !out_valid_q || out_ready;

    // Grant: explicit select (range-checked) or first valid channel scanning from rr_ptr
    always_comb begin
        grant    = '0;
        grant_ok = 1'b0;
        idx      = '0;
        if (!mode) begin
            grant    = sel;
            grant_ok = ({1'b0, sel} < NCH_W);
        end else begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                // wrap at N_CH rather than 2^SEL_W so non-power-of-two counts stay in range
                idx = {1'b0, rr_ptr_q} + (SEL_W+1)'(k);
                if (idx >= NCH_W) idx = idx - NCH_W;
                if (!grant_ok && in_valid[idx[SEL_W-1:0]]) begin
                    grant_ok = 1'b1;
                    grant    = idx[SEL_W-1:0];
                end
            end
        end
    end

    // Slice of the granted channel; non-granted data never reaches the register
    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (grant == SEL_W'(i)) grant_data = in_data[i*DATA_W +: DATA_W];
        end
    end

    // One-hot ready toward the granted channel, suppressed during reset and backpressure
    always_comb begin
        in_ready = '0;
        if (!rst && load && grant_ok) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                in_ready[i] = (grant == SEL_W'(i));
            end
        end
    end

    assign xfer = |(in_valid & in_ready);

    // Next state of the output stage and round-robin pointer
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = grant_data;
                out_ch_d   = grant;
                if (mode) rr_ptr_d = (grant == LAST) ? '0 : grant + 1'b1;
            end
        end
    end

    // Output register and pointer state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_n1.sv
// Testbench for stream_mux_n1: an 8-channel and a 5-channel instance share
// stimulus and are checked against a queue-free behavioural model.
module tb_stream_mux_n1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, mode, out_ready;
    logic [2:0]  sel;
    logic [63:0] in_data;
    logic [7:0]  in_valid;

    logic [7:0]  rdy8, od8;
    logic [2:0]  ch8;
    logic        ov8;
    logic [4:0]  rdy5;
    logic [7:0]  od5;
    logic [2:0]  ch5;
    logic        ov5;

    int passed = 0;
    int total  = 0;

    stream_mux_n1 #(.N_CH(8), .DATA_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(rdy8),
        .out_data(od8), .out_ch(ch8), .out_valid(ov8), .out_ready(out_ready)
    );

    stream_mux_n1 #(.N_CH(5), .DATA_W(8)) u_dut5 (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data[39:0]), .in_valid(in_valid[4:0]), .in_ready(rdy5),
        .out_data(od5), .out_ch(ch5), .out_valid(ov5), .out_ready(out_ready)
    );

    // Reference model state, index 0 = 8-channel DUT, 1 = 5-channel DUT
    int         nch[2]     = '{8, 5};
    bit         m_valid[2] = '{0, 0};
    logic [7:0] m_data[2]  = '{8'h00, 8'h00};
    int         m_ch[2]    = '{0, 0};
    int         m_ptr[2]   = '{0, 0};

    function automatic void mgrant(input int d, output int g, output bit ok);
        int n;
        n  = nch[d];
        g  = 0;
        ok = 0;
        if (!mode) begin
            g  = int'(sel);
            ok = (g < n);
        end else begin
            for (int k = 0; k < n; k++) begin
                int c;
                c = (m_ptr[d] + k) % n;
                if (!ok && in_valid[c]) begin
                    ok = 1;
                    g  = c;
                end
            end
        end
    endfunction

    function automatic logic [7:0] exp_ready(input int d);
        int g;
        bit ok;
        mgrant(d, g, ok);
        if (rst) return 8'h00;
        if ((!m_valid[d] || out_ready) && ok) return 8'(1 << g);
        return 8'h00;
    endfunction

    // Advance the model across one rising edge and settle 1 time unit after it
    task automatic tick();
        bit         ld[2];
        bit         xf[2];
        bit         ok[2];
        int         g[2];
        logic [7:0] dv[2];
        for (int d = 0; d < 2; d++) begin
            mgrant(d, g[d], ok[d]);
            ld[d] = !m_valid[d] || out_ready;
            xf[d] = ld[d] && ok[d] && in_valid[g[d]];
            dv[d] = in_data[g[d]*8 +: 8];
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_valid[d] = 0;
                m_data[d]  = 8'h00;
                m_ch[d]    = 0;
                m_ptr[d]   = 0;
            end else if (ld[d]) begin
                m_valid[d] = xf[d];
                if (xf[d]) begin
                    m_data[d] = dv[d];
                    m_ch[d]   = g[d];
                    if (mode) m_ptr[d] = (g[d] + 1) % nch[d];
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; sel = 3'd0; out_ready = 1'b1;
        in_valid = 8'hFF; in_data = {$urandom, $urandom};
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if ({rdy8, rdy5} !== 13'd0) $display("FAIL reset_ready: got %b/%b want 0", rdy8, rdy5);
            else passed++;
            tick();
            total++;
            if ({ov8, od8, ch8, ov5, od5, ch5} !== 24'd0)
                $display("FAIL reset_out: got v=%b d=%h ch=%0d / v=%b d=%h ch=%0d want all 0", ov8, od8, ch8, ov5, od5, ch5);
            else passed++;
        end
    endtask

    task automatic test_fixed_select();
        logic [7:0] e5;
        rst = 1'b0; mode = 1'b0; sel = 3'd3; out_ready = 1'b1;
        in_data = {$urandom, $urandom};
        in_data[31:24] = 8'hA5;
        in_valid = 8'($urandom) | 8'h08;
        #1;
        total++;
        if (rdy8 !== 8'b0000_1000) $display("FAIL fixed_ready: got %b want 00001000", rdy8);
        else passed++;
        e5 = exp_ready(1);
        total++;
        if (rdy5 !== e5[4:0]) $display("FAIL fixed_ready5: got %b want %b", rdy5, e5[4:0]);
        else passed++;
        tick();
        total++;
        if ({ov8, od8, ch8} !== {1'b1, 8'hA5, 3'd3})
            $display("FAIL fixed_out: got v=%b d=%h ch=%0d want v=1 d=a5 ch=3", ov8, od8, ch8);
        else passed++;
        total++;
        if ({ov5, od5, ch5} !== {m_valid[1], m_data[1], 3'(m_ch[1])})
            $display("FAIL fixed_out5: got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d", ov5, od5, ch5, m_valid[1], m_data[1], m_ch[1]);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [7:0] c1;
        out_ready = 1'b0;
        in_data[31:24] = 8'h5A;
        c1 = 8'($urandom);
        in_data[15:8] = c1;
        in_valid[1] = 1'b1;
        sel = 3'd1;
        for (int i = 0; i < 3; i++) begin
            mode = i[0];
            #1;
            total++;
            if ({rdy8, rdy5} !== 13'd0) $display("FAIL hold_ready: got %b/%b want 0", rdy8, rdy5);
            else passed++;
            tick();
            total++;
            if ({ov8, od8, ch8} !== {1'b1, 8'hA5, 3'd3})
                $display("FAIL hold_out: got v=%b d=%h ch=%0d want v=1 d=a5 ch=3", ov8, od8, ch8);
            else passed++;
        end
        mode = 1'b0;
        out_ready = 1'b1;
        #1;
        total++;
        if (rdy8 !== 8'b0000_0010) $display("FAIL release_ready: got %b want 00000010", rdy8);
        else passed++;
        tick();
        total++;
        if ({ov8, od8, ch8} !== {1'b1, c1, 3'd1})
            $display("FAIL release_out: got v=%b d=%h ch=%0d want v=1 d=%h ch=1", ov8, od8, ch8, c1);
        else passed++;
    endtask

    task automatic test_round_robin();
        mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = {$urandom, $urandom};
            tick();
            total++;
            if (ch8 !== 3'(i % 8) || {ov8, od8} !== {1'b1, m_data[0]})
                $display("FAIL rr_seq[%0d]: got v=%b d=%h ch=%0d want v=1 d=%h ch=%0d", i, ov8, od8, ch8, m_data[0], i % 8);
            else passed++;
        end
    endtask

    task automatic test_sparse();
        int want;
        in_valid = 8'b0010_0100;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) in_valid = 8'b0000_0100;
            in_data = {$urandom, $urandom};
            tick();
            want = (i < 4 && i[0]) ? 5 : 2;
            total++;
            if ({ov8, ch8} !== {1'b1, 3'(want)} || od8 !== in_data[want*8 +: 8])
                $display("FAIL sparse[%0d]: got v=%b d=%h ch=%0d want v=1 d=%h ch=%0d", i, ov8, od8, ch8, in_data[want*8 +: 8], want);
            else passed++;
        end
    endtask

    task automatic test_non_pow2();
        int prev;
        bit saw_wrap;
        mode = 1'b0; sel = 3'd6; in_valid = 8'hFF; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = {$urandom, $urandom};
            #1;
            total++;
            if (rdy5 !== 5'd0) $display("FAIL np2_ready: got %b want 00000", rdy5);
            else passed++;
            tick();
            total++;
            if (ov5 !== 1'b0) $display("FAIL np2_valid: got %b want 0", ov5);
            else passed++;
        end
        mode = 1'b1;
        prev = -1;
        saw_wrap = 0;
        for (int i = 0; i < 7; i++) begin
            in_data = {$urandom, $urandom};
            tick();
            total++;
            if ({ov5, od5, ch5} !== {m_valid[1], m_data[1], 3'(m_ch[1])})
                $display("FAIL np2_rr[%0d]: got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d", i, ov5, od5, ch5, m_valid[1], m_data[1], m_ch[1]);
            else passed++;
            if (prev == 4 && ch5 == 3'd0) saw_wrap = 1;
            prev = int'(ch5);
        end
        total++;
        if (saw_wrap !== 1'b1) $display("FAIL np2_wrap: got %b want 1 (4 -> 0)", saw_wrap);
        else passed++;
    endtask

    task automatic test_random();
        logic [7:0] e8, e5;
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 31) == 0);
            mode      = 1'($urandom);
            sel       = 3'($urandom);
            in_valid  = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            #1;
            e8 = exp_ready(0);
            e5 = exp_ready(1);
            total++;
            if ({rdy8, rdy5} !== {e8, e5[4:0]})
                $display("FAIL rand_ready[%0d]: got %b/%b want %b/%b", i, rdy8, rdy5, e8, e5[4:0]);
            else passed++;
            tick();
            total++;
            if ({ov8, od8, ch8, ov5, od5, ch5} !==
                {m_valid[0], m_data[0], 3'(m_ch[0]), m_valid[1], m_data[1], 3'(m_ch[1])})
                $display("FAIL rand_out[%0d]: got %b %h %0d / %b %h %0d want %b %h %0d / %b %h %0d", i,
                         ov8, od8, ch8, ov5, od5, ch5,
                         m_valid[0], m_data[0], m_ch[0], m_valid[1], m_data[1], m_ch[1]);
            else passed++;
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fixed_select();
        test_backpressure();
        test_round_robin();
        test_sparse();
        test_non_pow2();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
